// File: rtl/timer_pkg.sv
// Shared types and constants for the down_timer block.
package timer_pkg;

   // Status FSM states: waiting for a load, counting down, terminal count reached.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int TIMER_DEFAULT_N = 4;

endpackage

// File: rtl/timer_prescaler.sv
// Mod-PRESCALE enable divider: tick goes high on every PRESCALE-th cycle with adv=1.
// Used by down_timer only when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
   parameter int PRESCALE = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic adv,
   output logic tick
);

   localparam int W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
   localparam logic [W-1:0] INC  = W'(1);

   logic [W-1:0] cnt_reg;

   // tick marks the advancing cycle that completes a PRESCALE group.
   assign tick = adv && (cnt_reg == LAST);

   // Phase counter; wraps to zero on the tick so each decrement restarts the group.
   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         cnt_reg <= '0;
      end else if (adv) begin
         cnt_reg <= tick ? '0 : cnt_reg + INC;
      end
   end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter / timer with terminal-count pulse and optional auto-reload.
// Optional feature macro: TIMER_PRESCALE_EN (decrement only every PRESCALE-th enabled cycle).
module down_timer
   import timer_pkg::*;
#(
   parameter int N = TIMER_DEFAULT_N
`ifdef TIMER_PRESCALE_EN
   ,parameter int PRESCALE = 4
`endif
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         en,
   input  logic         auto_reload,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         busy
);

   localparam logic [N-1:0] ONE = N'(1);

   state_t       state_reg, state_next;
   logic [N-1:0] count_reg, count_next;
   logic [N-1:0] reload_reg, reload_next;
   logic         tc_reg, tc_next;
   logic         busy_reg;
   logic         step;

`ifdef TIMER_PRESCALE_EN
   // Prescaler advances only on enabled RUN cycles that are not overridden by a load.
   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (load),
      .adv   ((state_reg == RUN) && en && !load),
      .tick  (step)
   );
`else
   assign step = en;
`endif

   // Next-state and datapath decode; load wins over everything except reset.
   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      reload_next = reload_reg;
      tc_next     = 1'b0;
      if (load) begin
         reload_next = load_val;
         count_next  = load_val;
         if (load_val != '0) begin
            state_next = RUN;
         end else begin
            state_next = DONE;
            tc_next    = 1'b1;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               count_next = '0;
            end
            RUN: begin
               if (step) begin
                  if (count_reg > ONE) begin
                     count_next = count_reg - ONE;
                  end else begin
                     // Terminal count; count==0 here is unreachable but must not wrap.
                     tc_next = (count_reg == ONE);
                     if (tc_next && auto_reload && (reload_reg != '0)) begin
                        count_next = reload_reg;
                     end else begin
                        count_next = '0;
                        state_next = DONE;
                     end
                  end
               end
            end
            DONE: begin
               count_next = '0;
            end
            default: begin
               count_next = '0;
               state_next = IDLE;
            end
         endcase
      end
   end

   // State and output registers; busy is decoded from the next state so it lines up with count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         reload_reg <= '0;
         tc_reg     <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         reload_reg <= reload_next;
         tc_reg     <= tc_next;
         busy_reg   <= (state_next == RUN);
      end
   end

   assign count = count_reg;
   assign tc    = tc_reg;
   assign busy  = busy_reg;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus random stimulus
// checked against a behavioural model of the timer rules.
module tb_down_timer;

   localparam int N = 4;
`ifdef TIMER_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         load = 1'b0;
   logic [N-1:0] load_val = '0;
   logic         en = 1'b0;
   logic         auto_reload = 1'b0;
   logic [N-1:0] count;
   logic         tc;
   logic         busy;

   int total = 0;
   int bad = 0;

   // Behavioural model: remaining count, whether a countdown is active, stored start value,
   // enabled cycles accumulated toward the next decrement, and the tc pulse.
   int m_count = 0;
   bit m_active = 0;
   int m_reload = 0;
   int m_pre = 0;
   bit m_tc = 0;

   always #5 clk = ~clk;

`ifdef TIMER_PRESCALE_EN
   down_timer #(.N(N), .PRESCALE(PS)) dut (
`else
   down_timer #(.N(N)) dut (
`endif
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .load_val    (load_val),
      .en          (en),
      .auto_reload (auto_reload),
      .count       (count),
      .tc          (tc),
      .busy        (busy)
   );

   // Apply one set of inputs across a rising edge and advance the model by the same edge.
   task automatic cycle(input bit rst_n, input bit ld, input int lv, input bit e, input bit ar);
      reset       = rst_n;
      load        = ld;
      load_val    = N'(lv);
      en          = e;
      auto_reload = ar;
      @(posedge clk);
      m_tc = 0;
      if (!rst_n) begin
         m_count = 0; m_active = 0; m_reload = 0; m_pre = 0;
      end else if (ld) begin
         m_reload = lv; m_count = lv; m_pre = 0;
         m_active = (lv != 0);
         m_tc = (lv == 0);
      end else if (m_active && e) begin
         m_pre = m_pre + 1;
         if (m_pre >= PS) begin
            m_pre = 0;
            if (m_count > 1) begin
               m_count = m_count - 1;
            end else begin
               m_tc = 1;
               if (ar && m_reload != 0) m_count = m_reload;
               else begin m_count = 0; m_active = 0; end
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(0, 1, 7, 1, 0);
      cycle(0, 1, 7, 1, 0);
      total++; if (count !== 4'b0000) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b want=0", tc); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      cycle(1, 0, 0, 0, 0);
      total++; if (count !== 4'b0000) begin bad++; $display("FAIL reset_release_count got=%0d want=0", count); end
      $display("test_reset: count=%0d tc=%b busy=%b", count, tc, busy);
   endtask

   task automatic test_countdown();
      int exp_c[4]  = '{2, 1, 0, 0};
      int exp_tc[4] = '{0, 0, 1, 0};
      int exp_b[4]  = '{1, 1, 0, 0};
      cycle(1, 1, 3, 0, 0);
      total++; if (count !== 4'd3 || busy !== 1'b1 || tc !== 1'b0) begin
         bad++; $display("FAIL countdown_load got=%0d/%b/%b want=3/1/0", count, busy, tc); end
      for (int i = 0; i < 4 * PS; i++) begin
         cycle(1, 0, 0, 1, 0);
         total++; if (count !== N'(m_count) || tc !== m_tc || busy !== m_active) begin
            bad++; $display("FAIL countdown_step%0d got=%0d/%b/%b want=%0d/%b/%b", i, count, tc, busy, m_count, m_tc, m_active); end
         if (PS == 1) begin
            total++; if (count !== N'(exp_c[i]) || tc !== exp_tc[i][0] || busy !== exp_b[i][0]) begin
               bad++; $display("FAIL countdown_seq%0d got=%0d/%b/%b want=%0d/%0d/%0d", i, count, tc, busy, exp_c[i], exp_tc[i], exp_b[i]); end
         end
         $display("test_countdown: count=%0d tc=%b busy=%b", count, tc, busy);
      end
   endtask

   task automatic test_auto_reload();
      int tcs = 0;
      cycle(1, 1, 2, 0, 1);
      for (int i = 0; i < 6 * PS; i++) begin
         cycle(1, 0, 0, 1, 1);
         if (tc) tcs++;
         total++; if (count !== N'(m_count) || tc !== m_tc || busy !== 1'b1) begin
            bad++; $display("FAIL auto_reload_step%0d got=%0d/%b/%b want=%0d/%b/1", i, count, tc, busy, m_count, m_tc); end
         total++; if (tc && count !== 4'd2) begin
            bad++; $display("FAIL auto_reload_value got=%0d want=2", count); end
         $display("test_auto_reload: count=%0d tc=%b busy=%b", count, tc, busy);
      end
      total++; if (tcs !== 3) begin bad++; $display("FAIL auto_reload_pulses got=%0d want=3", tcs); end
   endtask

   task automatic test_enable_gating();
      cycle(1, 1, 5, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 0, 0, 0);
         total++; if (count !== 4'd5 || tc !== 1'b0) begin
            bad++; $display("FAIL gating_hold%0d got=%0d/%b want=5/0", i, count, tc); end
      end
      for (int i = 0; i < PS; i++) cycle(1, 0, 0, 1, 0);
      total++; if (count !== 4'd4) begin bad++; $display("FAIL gating_step got=%0d want=4", count); end
      $display("test_enable_gating: count=%0d tc=%b busy=%b", count, tc, busy);
   endtask

   task automatic test_midrun();
      int guard = 0;
      cycle(1, 1, 5, 0, 0);
      while (m_count != 2 && guard < 100) begin cycle(1, 0, 0, 1, 0); guard++; end
      total++; if (count !== 4'd2) begin bad++; $display("FAIL midrun_reach2 got=%0d want=2", count); end
      cycle(1, 1, 9, 1, 0);
      total++; if (count !== 4'd9 || tc !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL midrun_load got=%0d/%b/%b want=9/0/1", count, tc, busy); end
      guard = 0;
      while (m_count != 6 && guard < 100) begin cycle(1, 0, 0, 1, 0); guard++; end
      total++; if (count !== 4'd6) begin bad++; $display("FAIL midrun_reach6 got=%0d want=6", count); end
      cycle(0, 0, 0, 1, 0);
      total++; if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL midrun_reset got=%0d/%b/%b want=0/0/0", count, tc, busy); end
      cycle(1, 0, 0, 1, 0);
      total++; if (count !== 4'd0 || busy !== 1'b0) begin
         bad++; $display("FAIL midrun_idle got=%0d/%b want=0/0", count, busy); end
      $display("test_midrun: count=%0d tc=%b busy=%b", count, tc, busy);
   endtask

   task automatic test_zero_load();
      int edges = 0;
      cycle(1, 1, 0, 1, 0);
      total++; if (count !== 4'd0 || tc !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL zero_load got=%0d/%b/%b want=0/1/0", count, tc, busy); end
      cycle(1, 0, 0, 1, 0);
      total++; if (tc !== 1'b0 || count !== 4'd0) begin
         bad++; $display("FAIL zero_load_after got=%0d/%b want=0/0", count, tc); end
      cycle(1, 1, 2, 0, 0);
      while (!tc && edges < 40) begin cycle(1, 0, 0, 1, 0); edges++; end
      total++; if (edges !== 2 * PS) begin
         bad++; $display("FAIL tc_latency got=%0d want=%0d", edges, 2 * PS); end
      $display("test_zero_load: tc_after=%0d edges", edges);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bit r  = ($urandom_range(0, 49) != 0);
         bit ld = ($urandom_range(0, 9) == 0);
         int lv = $urandom_range(0, 15);
         bit e  = ($urandom_range(0, 3) != 0);
         bit ar = $urandom_range(0, 1);
         cycle(r, ld, lv, e, ar);
         total++; if (count !== N'(m_count) || tc !== m_tc || busy !== m_active) begin
            bad++; $display("FAIL random%0d got=%0d/%b/%b want=%0d/%b/%b", i, count, tc, busy, m_count, m_tc, m_active); end
         $display("test_random %0d: r=%b ld=%b lv=%0d en=%b ar=%b -> count=%0d tc=%b busy=%b", i, r, ld, lv, e, ar, count, tc, busy);
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_auto_reload();
      test_enable_gating();
      test_midrun();
      test_zero_load();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counter and timer. It counts the opposite way to the team's up-counter: it loads a start value, decrements on enabled clocks and flags terminal count at zero. It feeds delay and timeout logic in the lab designs.
- Optional auto-reload gives periodic tick generation.
- A small FSM tracks idle, run and done status.

Parameters:
N, 4, width of count, load value and reload register.
PRESCALE, 4, enabled cycles per decrement; only used when TIMER_PRESCALE_EN is defined; legal range is 2 or more.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous active-low reset; sampled on the rising edge of clk.
load  input  1  load load_val and start; has priority over en.
load_val  input  N  start value captured when load=1.
en  input  1  decrement enable, RUN state only.
auto_reload  input  1  on terminal count, reload the captured start value instead of stopping.
count  output  N  current count value.
tc  output  1  terminal-count pulse, one cycle wide.
busy  output  1  high while state is RUN.

Behaviour:
- Reset: on any edge with reset=0:
  - count=0, tc=0, busy=0, reload_reg=0, state=IDLE.
  - Reset overrides load and en, including mid-run; no tc is generated.
- All outputs are registered.
- count, tc and busy change only on clk edges, one cycle after the causing input.
- FSM states are IDLE, RUN and DONE.
- Load, from any state when load=1:
  - reload_reg<=load_val and count<=load_val.
  - If load_val!=0: next state RUN.
  - If load_val==0: next state DONE and tc<=1.
  - Load restarts a running count and suppresses any tc for that edge.
- IDLE with no load: hold count=0, tc=0.
- RUN with en=1 and count>1: count<=count-1.
- RUN with en=1 and count==1, terminal count: tc<=1.
  - If auto_reload=1 and reload_reg!=0: count<=reload_reg and stay in RUN. count never shows 0 in this case.
  - Otherwise count<=0 and next state DONE.
- RUN with en=0: hold count; tc=0.
- DONE with no load: count holds 0, tc=0; stays in DONE until load or reset.
- tc is high for exactly one cycle per terminal count event.
- busy is a registered decode of state==RUN:
  - busy=1 in the cycle the loaded value first appears when load_val!=0.
  - busy=0 in the same cycle that count shows 0 or tc is asserted on entry to DONE.
- No wrap-around to 2^N-1 is ever permitted; the decrement never goes below 0.
- auto_reload is sampled only at the terminal-count edge.

Optional Feature:
TIMER_PRESCALE_EN.
- Defined:
  - An internal prescale counter advances on RUN cycles with en=1.
  - count decrements only on every PRESCALE-th such cycle.
  - The prescale counter clears on load, on reset and on each decrement.
  - tc and reload timing follow the gated decrement.
- Undefined: every RUN cycle with en=1 decrements. No prescale logic is instantiated and PRESCALE is ignored.

Decomposition:
- Package timer_pkg holds:
  - state_t, an enum of IDLE, RUN, DONE.
  - Constant TIMER_DEFAULT_N=4.
- One sub-module, timer_prescaler, a parameterised mod-PRESCALE enable divider with clr. It is instantiated only under TIMER_PRESCALE_EN.
- The FSM and datapath stay in down_timer.

Test Plan:
- Reset: hold reset=0 for 2 edges with load=1, load_val=4'd7 -> count=4'b0000, tc=0, busy=0, and count stays 0 after reset is released with load=0.
- Basic countdown: load=1, load_val=3, then en=1 for 4 edges -> count 3,2,1,0, busy=1,1,1,0, tc=0,0,0,1, then tc=0 with count held 0.
- Auto-reload: auto_reload=1, load 2, en=1 continuous -> count 2,1,2,1,2, with tc=1 exactly on the cycles count returns to 2; busy stays 1.
- Enable gating: load 5, en=0 for 3 edges -> count=5 throughout, tc=0; then en=1 for 1 edge -> count=4.
- Mid-run load and reset:
  - At count=2, load=1 with load_val=9 -> count=9 on the next edge, no tc.
  - Later, at count=6, reset=0 -> count=0, tc=0, busy=0, state IDLE.
- Zero load and prescale: load_val=0 -> count=0, tc=1 for one cycle, busy=0. With TIMER_PRESCALE_EN and PRESCALE=4, load 2 with en=1 -> tc after exactly 8 enabled edges.
